div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter DIV_ITER, default 32, number of radix-2 iterations (one per quotient bit).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 startE  input  1  div/divu instruction present in execute stage; held high until result accepted.
REQ-005 signedE  input  1  1 = div (two's complement), 0 = divu.
REQ-006 opaE  input  32  dividend (rs value).
REQ-007 opbE  input  32  divisor (rt value).
REQ-008 cancel  input  1  flush/exception kill of the in-flight divide.
REQ-009 div_stall  output  1  freeze pipeline stages F/D/E while divide runs.
REQ-010 div_valid  output  1  one-cycle pulse: hi_o/lo_o hold a final result for HI/LO write.
REQ-011 hi_o  output  32  remainder.
REQ-012 lo_o  output  32  quotient.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; the FSM SHALL start in IDLE.
REQ-014 IDLE & startE & !cancel & opbE!=0: latch |opaE|, |opbE| (absolute values only when signedE), sign flags, clear iteration counter; go to BUSY.
REQ-015 IDLE & startE & !cancel & opbE==0: lo_o=32'hFFFFFFFF, hi_o=opaE; go to DONE (no BUSY cycles).
REQ-016 BUSY: one restoring shift-subtract step per cycle (33-bit partial remainder); counter increments; after DIV_ITER steps go to DONE.
REQ-017 Entering DONE: apply sign fix -- quotient negated when signs differ, remainder takes dividend sign (signed only); register into lo_o/hi_o.
REQ-018 DONE: div_valid=1 for exactly one cycle; startE ignored; next state IDLE unconditionally.
REQ-019 div_stall = (IDLE & startE & !cancel) | BUSY; combinational; 0 in DONE so the pipeline advances on the valid cycle.
REQ-020 Latency (nonzero divisor): start accepted cycle 0, div_stall high cycles 0..DIV_ITER (33 cycles), div_valid at cycle DIV_ITER+1 (33).
REQ-021 Latency (zero divisor): div_stall high cycle 0, div_valid cycle 1.
REQ-022 cancel in any state: next state IDLE, div_stall=0 same cycle, no div_valid pulse for that operation; cancel has priority over startE.
REQ-023 Back-to-back: a new startE is accepted only in IDLE, i.e. earliest the cycle after DONE.
REQ-024 Operand inputs sampled only at acceptance; later changes on opaE/opbE do not affect the result.
REQ-025 Signed overflow 0x80000000 / -1: lo_o=0x80000000, hi_o=0 (natural wraparound of the algorithm).
REQ-026 hi_o/lo_o hold their last value outside DONE; consumers qualify with div_valid.

Reset
REQ-027 rst high at a rising edge: state IDLE, counter 0, hi_o=0, lo_o=0, div_valid=0, internal operand/remainder registers 0.
REQ-028 rst overrides cancel and startE; reset mid-BUSY aborts with no div_valid pulse.
REQ-029 Cycle after rst deasserts, a held startE is accepted as a fresh operation.

Structure
REQ-030 Shared package holds the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), DIV_ITER default, and the zero-divisor quotient constant 32'hFFFFFFFF.
REQ-031 One sub-module div_step: combinational single restoring iteration (partial remainder, quotient shift in); div_ctrl owns the FSM, counter, sign fixup and registers.
REQ-032 div_ctrl drives the HI/LO write-enable path of the execute stage alongside hilowriteE; it does not decode instructions.

Verification
REQ-033 divu 100/7 -> stall 33 cycles, div_valid at cycle 33, lo_o=14, hi_o=2.
REQ-034 div -100/7 -> lo_o=32'hFFFFFFF2, hi_o=32'hFFFFFFFE; div 100/-7 -> lo_o=32'hFFFFFFF2, hi_o=2.
REQ-035 divu 5/0 -> div_valid at cycle 1, lo_o=32'hFFFFFFFF, hi_o=5, stall one cycle only.
REQ-036 cancel at cycle 10 of BUSY -> IDLE next cycle, stall drops immediately, no div_valid; subsequent divu 9/3 gives lo_o=3, hi_o=0 at its cycle 33.
REQ-037 rst at cycle 20 of BUSY -> all outputs 0, no div_valid; startE held through reset accepted on first post-reset cycle.
REQ-038 Two consecutive divides (startE re-asserted in cycle after DONE) -> two valid pulses 34 cycles apart, each result correct, including 0x80000000 / -1 -> lo_o=0x80000000, hi_o=0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative HI/LO divider: FSM encoding, iteration
// default, divide-by-zero quotient and a magnitude helper.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int          DIV_ITER_DEF = 32;
  localparam logic [31:0] DIV0_QUO     = 32'hFFFF_FFFF;

  // Magnitude of v when interpreted as two's complement (only when sgn is set).
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider handshake: operands in, stall/valid/HI/LO out.
interface div_ctrl_if;
  logic        startE;
  logic        signedE;
  logic [31:0] opaE;
  logic [31:0] opbE;
  logic        cancel;
  logic        div_stall;
  logic        div_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output startE, signedE, opaE, opbE, cancel,
    input  div_stall, div_valid, hi_o, lo_o
  );

  modport slave (
    input  startE, signedE, opaE, opbE, cancel,
    output div_stall, div_valid, hi_o, lo_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into a
// 33-bit partial remainder and shifts the resulting quotient bit in.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);
  logic [32:0] part;
  logic [32:0] diff;

  always_comb begin
    part = {rem_i, quo_i[31]};
    diff = part - {1'b0, dvs_i};
    // Non-negative trial difference means the divisor fits: keep it, quotient bit 1.
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = part[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Multicycle div/divu controller: magnitude divide over DIV_ITER cycles, sign
// fixup on the way into DONE, one-cycle valid pulse for the HI/LO write.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  dif
);
  localparam int                CNT_W    = $clog2(DIV_ITER + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DIV_ITER - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       dvs_q, dvs_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [31:0]       step_rem, step_quo;
  logic              stall, valid;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    stall   = 1'b0;
    valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dif.startE) begin
          stall = 1'b1;
          if (dif.opbE == '0) begin
            lo_d    = DIV0_QUO;
            hi_d    = dif.opaE;
            state_d = DONE;
          end else begin
            quo_d   = abs32(dif.opaE, dif.signedE);
            dvs_d   = abs32(dif.opbE, dif.signedE);
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = dif.signedE & (dif.opaE[31] ^ dif.opbE[31]);
            negr_d  = dif.signedE & dif.opaE[31];
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          lo_d    = negq_q ? 32'(-step_quo) : step_quo;
          hi_d    = negr_q ? 32'(-step_rem) : step_rem;
          state_d = DONE;
        end
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A killed operation must leave no trace on HI/LO and release the pipeline now.
    if (dif.cancel) begin
      state_d = IDLE;
      stall   = 1'b0;
      valid   = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign dif.div_stall = stall;
  assign dif.div_valid = valid;
  assign dif.hi_o      = hi_q;
  assign dif.lo_o      = lo_q;
endmodule
